cla_subtractor_pipe: RTL and testbench
======================================

Name: cla_subtractor_pipe

Overview:
- Pipelined WIDTH-bit subtractor computing diff = a - b - bin.
- Built from SLICE-bit carry-lookahead slices. Each pipeline stage resolves one slice and passes the borrow to the next stage.
- Valid/ready handshakes on input and output; accepts one operation per cycle.
- Serves as the subtract/compare datapath alongside the existing 8-bit carry-lookahead adder; also provides signed and unsigned flags.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits resolved per stage. STAGES = WIDTH/SLICE (default 4).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, bin are valid this cycle.
- in_ready  output  1  block accepts the operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in, for chaining wider subtractions.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- zero  output  1  diff == 0.
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
- Arithmetic: diff = a + ~b + ~bin.
- Slice k computes g = a_k & ~b_k and p = a_k ^ ~b_k, with carry-lookahead across the SLICE bits.
  - carry_in of slice 0 = ~bin.
  - carry_in of slice k = carry_out of slice k-1, registered.
- bout = ~carry_out of the top slice.
- ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
- zero is computed in the final stage from the complete diff.
- Pipeline: STAGES register stages, each holding:
  - a valid bit,
  - the already-resolved lower diff slices,
  - the still-unresolved upper a/b slices,
  - the registered carry,
  - the a/b MSBs for the ovf calculation.
- Global enable: en = ~out_valid | out_ready; in_ready = en.
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - When en = 0, every stage register holds, including valid bits and data.
  - When en = 1, every stage advances; stage 0 loads the new operands with valid = in_valid.
- Latency: an operation accepted at edge N is presented with out_valid = 1 after edge N+STAGES-1, i.e. out_valid rises STAGES cycles after acceptance (4 by default).
- Throughput: one operation per cycle while out_ready = 1. Bubbles (in_valid = 0) propagate as valid = 0 entries.
- Output fields are driven from the final stage register and are stable while out_valid = 1 & out_ready = 0.
- Reset (asynchronous, any time, including mid-operation):
  - All valid bits clear, so out_valid = 0.
  - diff, bout, zero, ovf = 0.
  - In-flight operations are discarded; none is ever emitted after reset.
  - in_ready = 1 immediately while rst is asserted and after release.
- Boundaries:
  - a == b with bin = 0 gives zero = 1, bout = 0.
  - b = 0 and bin = 1 borrows through every slice.
  - 0 - max wraps to 1 with bout = 1.
  - Simultaneous in-transfer and out-transfer in the same cycle is legal when out_ready = 1.
  - out_ready may toggle arbitrarily; no result may be lost or duplicated.

Decomposition:
- Shared package: SLICE default and STAGES derivation, a function for the ovf expression, and the stage-register struct typedef {valid, a_hi, b_hi, diff_lo, carry, sa, sb}.
- One sub-module: cla_sub_slice, a combinational SLICE-bit carry-lookahead slice.
  - Inputs: a, b (already inverted by the caller), carry-in.
  - Outputs: sum, carry-out.
  - Instantiated STAGES times via generate.

Test Plan:
- Basic, out_ready = 1: a = 0x00000005, b = 0x00000003, bin = 0 -> 4 cycles later diff = 0x00000002, bout = 0, zero = 0, ovf = 0.
- Wrap and signed overflow, back-to-back on consecutive cycles:
  - 0x00000000 - 0x00000001 -> diff = 0xFFFFFFFF, bout = 1, ovf = 0.
  - 0x80000000 - 0x00000001 -> diff = 0x7FFFFFFF, bout = 0, ovf = 1.
  - Results appear on consecutive cycles in order.
- Full-width borrow ripple: a = 0x12345678, b = 0x12345678, bin = 0 -> diff = 0, zero = 1, bout = 0. Same operands with bin = 1 -> diff = 0xFFFFFFFF, bout = 1, zero = 0.
- Backpressure:
  - Push 6 operations while out_ready = 0 -> in_ready drops after the pipeline fills, with exactly 4 operations accepted.
  - Outputs stay stable while stalled.
  - Releasing out_ready drains all results in order; none is lost or duplicated.
- Reset mid-flight: assert rst asynchronously with 3 operations in flight -> out_valid = 0 and diff = 0 immediately; no stale result after release. A new operation (9 - 4) yields diff = 5 after 4 cycles.
- Random compare: 10k random a, b, bin with random in_valid/out_ready -> every result matches the reference model {bout, diff} = {1'b0, a} - b - bin, with ovf and zero checked; ordering is preserved.

Source files
------------

// File: rtl/cla_subtractor_pipe_pkg.sv
// cla_subtractor_pipe_pkg
//   Shared definitions for the pipelined carry-lookahead subtractor:
//   default operand/slice widths, stage-count derivation, the signed
//   overflow expression and the per-stage pipeline register layout.
package cla_subtractor_pipe_pkg;

    localparam int unsigned CSP_WIDTH = 32;
    localparam int unsigned CSP_SLICE = 8;

    function automatic int unsigned csp_stages(input int unsigned width,
                                               input int unsigned slice);
        return width / slice;
    endfunction

    // Signed overflow of a - b: operands of differing sign and a result
    // whose sign differs from the minuend.
    function automatic logic csp_ovf(input logic sa, input logic sb, input logic sd);
        return (sa ^ sb) & (sd ^ sa);
    endfunction

    // One pipeline stage. a_hi/b_hi carry the full operands; only the slices
    // above the ones already resolved into diff_lo are consumed downstream.
    typedef struct packed {
        logic                 valid;
        logic [CSP_WIDTH-1:0] a_hi;
        logic [CSP_WIDTH-1:0] b_hi;
        logic [CSP_WIDTH-1:0] diff_lo;
        logic                 carry;
        logic                 sa;
        logic                 sb;
    } csp_stage_t;

endpackage

// File: rtl/cla_subtractor_pipe_slice.sv
// cla_sub_slice
//   Combinational SLICE-bit carry-lookahead adder slice. The caller supplies
//   the subtrahend already inverted, so this is a plain a + b + c_i.
//   Ports:
//     a_i   [SLICE] minuend slice
//     b_i   [SLICE] inverted subtrahend slice
//     c_i           carry-in (not-borrow)
//     sum_o [SLICE] slice sum
//     c_o           carry-out (not-borrow)
module cla_sub_slice
    import cla_subtractor_pipe_pkg::*;
#(
    parameter int unsigned SLICE = CSP_SLICE
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] sum_o,
    output logic             c_o
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             acc;
    logic             prop;

    // Each carry is the flattened lookahead sum-of-products:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c_i
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c    = '0;
        acc  = 1'b0;
        prop = 1'b0;
        c[0] = c_i;
        for (int unsigned i = 0; i < SLICE; i++) begin
            acc  = g[i];
            prop = p[i];
            for (int unsigned j = 0; j < i; j++) begin
                acc  = acc | (prop & g[i-1-j]);
                prop = prop & p[i-1-j];
            end
            c[i+1] = acc | (prop & c_i);
        end
    end

    assign sum_o = p ^ c[SLICE-1:0];
    assign c_o   = c[SLICE];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// cla_subtractor_pipe
//   Pipelined WIDTH-bit subtractor: diff = a - b - bin, one SLICE-bit
//   carry-lookahead slice resolved per stage, valid/ready on both sides.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   input handshake for a, b, bin
//     a, b  [WIDTH]       minuend, subtrahend
//     bin                 borrow-in
//     out_valid/out_ready output handshake
//     diff  [WIDTH]       a - b - bin modulo 2^WIDTH
//     bout                borrow-out (unsigned a < b + bin)
//     zero                diff == 0
//     ovf                 signed overflow
module cla_subtractor_pipe
    import cla_subtractor_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = CSP_WIDTH,
    parameter int unsigned SLICE = CSP_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned STAGES = csp_stages(WIDTH, SLICE);

    // The stage struct is sized by the package defaults.
    if (WIDTH != CSP_WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("cla_subtractor_pipe: WIDTH must equal CSP_WIDTH and be a multiple of SLICE");
    end

    csp_stage_t st_q [STAGES];
    csp_stage_t st_d [STAGES];

    logic [SLICE-1:0] sl_a   [STAGES];
    logic [SLICE-1:0] sl_b   [STAGES];
    logic [SLICE-1:0] sl_sum [STAGES];
    logic             sl_ci  [STAGES];
    logic             sl_co  [STAGES];

    logic en;

    // Slice 0 resolves straight from the inputs ahead of stage 0, so each
    // register stage k holds slices 0..k resolved.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_first
            assign sl_a[k]  = a[SLICE-1:0];
            assign sl_b[k]  = ~b[SLICE-1:0];
            assign sl_ci[k] = ~bin;
        end else begin : g_rest
            assign sl_a[k]  = st_q[k-1].a_hi[k*SLICE +: SLICE];
            assign sl_b[k]  = ~st_q[k-1].b_hi[k*SLICE +: SLICE];
            assign sl_ci[k] = st_q[k-1].carry;
        end

        cla_sub_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a_i   (sl_a[k]),
            .b_i   (sl_b[k]),
            .c_i   (sl_ci[k]),
            .sum_o (sl_sum[k]),
            .c_o   (sl_co[k])
        );
    end

    assign en       = ~st_q[STAGES-1].valid | out_ready;
    assign in_ready = en;

    always_comb begin
        st_d[0]                     = '0;
        st_d[0].valid               = in_valid;
        st_d[0].a_hi                = a;
        st_d[0].b_hi                = b;
        st_d[0].diff_lo[SLICE-1:0]  = sl_sum[0];
        st_d[0].carry               = sl_co[0];
        st_d[0].sa                  = a[WIDTH-1];
        st_d[0].sb                  = b[WIDTH-1];
        for (int unsigned k = 1; k < STAGES; k++) begin
            st_d[k]                           = st_q[k-1];
            st_d[k].diff_lo[k*SLICE +: SLICE] = sl_sum[k];
            st_d[k].carry                     = sl_co[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    // Result fields are masked by the final valid bit so bubbles and the
    // reset state present all-zero flags.
    assign out_valid = st_q[STAGES-1].valid;
    assign diff      = out_valid ? st_q[STAGES-1].diff_lo : '0;
    assign bout      = out_valid & ~st_q[STAGES-1].carry;
    assign zero      = out_valid & (st_q[STAGES-1].diff_lo == '0);
    assign ovf       = out_valid & csp_ovf(st_q[STAGES-1].sa, st_q[STAGES-1].sb,
                                           st_q[STAGES-1].diff_lo[WIDTH-1]);

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
module tb_cla_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cla_subtractor_pipe #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    // Result packing used throughout: {ovf, zero, bout, diff}
    function automatic logic [34:0] ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                              input logic rbi);
        logic [32:0] w;
        longint      s;
        logic        ov;
        w  = {1'b0, ra} - {1'b0, rb} - {32'b0, rbi};
        s  = longint'($signed(ra)) - longint'($signed(rb)) - longint'(rbi);
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {ov, (w[31:0] == 32'h0), w[32], w[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if ({ovf, zero, bout, diff} !== 35'h0) begin n_bad++; $display("FAIL rst_fields got %h want 0", {ovf, zero, bout, diff}); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        a = 32'h5; b = 32'h3; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid cyc %0d got %b want 0", i, out_valid); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", out_valid); end
        n_cmp++; if ({ovf, zero, bout, diff} !== {3'b000, 32'h00000002}) begin
            n_bad++; $display("FAIL basic_result got %h want %h", {ovf, zero, bout, diff}, {3'b000, 32'h00000002});
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_dup got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        a = 32'h00000000; b = 32'h00000001; bin = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'h80000000; b = 32'h00000001; bin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if ({out_valid, ovf, zero, bout, diff} !== {1'b1, 3'b001, 32'hFFFFFFFF}) begin
            n_bad++; $display("FAIL wrap_result got %h want %h", {out_valid, ovf, zero, bout, diff}, {1'b1, 3'b001, 32'hFFFFFFFF});
        end
        tick();
        n_cmp++; if ({out_valid, ovf, zero, bout, diff} !== {1'b1, 3'b100, 32'h7FFFFFFF}) begin
            n_bad++; $display("FAIL sovf_result got %h want %h", {out_valid, ovf, zero, bout, diff}, {1'b1, 3'b100, 32'h7FFFFFFF});
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_dup got %b want 0", out_valid); end
    endtask

    task automatic test_borrow_ripple();
        out_ready = 1'b1;
        a = 32'h12345678; b = 32'h12345678; bin = 1'b0; in_valid = 1'b1;
        tick();
        bin = 1'b1;
        tick();
        in_valid = 1'b0; bin = 1'b0;
        tick();
        tick();
        n_cmp++; if ({out_valid, ovf, zero, bout, diff} !== {1'b1, 3'b010, 32'h00000000}) begin
            n_bad++; $display("FAIL equal_result got %h want %h", {out_valid, ovf, zero, bout, diff}, {1'b1, 3'b010, 32'h00000000});
        end
        tick();
        n_cmp++; if ({out_valid, ovf, zero, bout, diff} !== {1'b1, 3'b001, 32'hFFFFFFFF}) begin
            n_bad++; $display("FAIL ripple_result got %h want %h", {out_valid, ovf, zero, bout, diff}, {1'b1, 3'b001, 32'hFFFFFFFF});
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic        vi [6];
        logic [34:0] ve [6];
        int sent;
        int got;
        int extra;
        logic fire;
        va[0] = 32'd10;        vb[0] = 32'd3;         vi[0] = 1'b0; ve[0] = {3'b000, 32'h00000007};
        va[1] = 32'h100;       vb[1] = 32'h1;         vi[1] = 1'b0; ve[1] = {3'b000, 32'h000000FF};
        va[2] = 32'hFFFFFFFF;  vb[2] = 32'hFFFFFFFF;  vi[2] = 1'b0; ve[2] = {3'b010, 32'h00000000};
        va[3] = 32'h1;         vb[3] = 32'h2;         vi[3] = 1'b0; ve[3] = {3'b001, 32'hFFFFFFFF};
        va[4] = 32'h7FFFFFFF;  vb[4] = 32'hFFFFFFFF;  vi[4] = 1'b0; ve[4] = {3'b101, 32'h80000000};
        va[5] = 32'h00010000;  vb[5] = 32'h1;         vi[5] = 1'b1; ve[5] = {3'b000, 32'h0000FFFE};
        sent = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (sent < 6);
            if (sent < 6) begin a = va[sent]; b = vb[sent]; bin = vi[sent]; end
            #1;
            fire = in_valid & in_ready;
            tick();
            if (fire) sent++;
        end
        n_cmp++; if (sent !== 4) begin n_bad++; $display("FAIL bp_accepted got %0d want 4", sent); end
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if ({out_valid, ovf, zero, bout, diff} !== {1'b1, ve[0]}) begin
                n_bad++; $display("FAIL bp_stall_hold cyc %0d got %h want %h", c, {out_valid, ovf, zero, bout, diff}, {1'b1, ve[0]});
            end
            tick();
        end
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid = (sent < 6);
            if (sent < 6) begin a = va[sent]; b = vb[sent]; bin = vi[sent]; end
            #1;
            if (out_valid && out_ready) begin
                n_cmp++; if ({ovf, zero, bout, diff} !== ve[got]) begin
                    n_bad++; $display("FAIL bp_drain idx %0d got %h want %h", got, {ovf, zero, bout, diff}, ve[got]);
                end
                got++;
            end
            fire = in_valid & in_ready;
            tick();
            if (fire) sent++;
        end
        n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL bp_drain_count got %0d want 6", got); end
        in_valid = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) extra++;
            tick();
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL bp_duplicate got %0d extra want 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 32'd20; b = 32'd1; bin = 1'b0; tick();
        a = 32'd30; b = 32'd2; tick();
        a = 32'd40; b = 32'd3; tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if ({out_valid, diff} !== {1'b1, 32'd19}) begin
            n_bad++; $display("FAIL mid_pre_reset got %h want %h", {out_valid, diff}, {1'b1, 32'd19});
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if ({out_valid, in_ready, ovf, zero, bout, diff} !== {2'b01, 35'h0}) begin
            n_bad++; $display("FAIL mid_reset_now got %h want %h", {out_valid, in_ready, ovf, zero, bout, diff}, {2'b01, 35'h0});
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_stale got %0d results want 0", seen); end
        a = 32'd9; b = 32'd4; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if ({out_valid, ovf, zero, bout, diff} !== {1'b1, 3'b000, 32'd5}) begin
            n_bad++; $display("FAIL mid_after_result got %h want %h", {out_valid, ovf, zero, bout, diff}, {1'b1, 3'b000, 32'd5});
        end
        tick();
    endtask

    task automatic test_random();
        logic [34:0] q [$];
        logic [34:0] exp_v;
        int pushed;
        int spurious;
        int cyc;
        logic fire;
        pushed = 0;
        spurious = 0;
        cyc = 0;
        while ((pushed < 10000 || q.size() != 0) && cyc < 60000) begin
            in_valid  = (pushed < 10000) && ($urandom_range(0, 3) != 0);
            a         = $urandom;
            b         = ($urandom_range(0, 7) == 0) ? a : $urandom;
            bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    spurious++;
                end else begin
                    exp_v = q.pop_front();
                    n_cmp++; if ({ovf, zero, bout, diff} !== exp_v) begin
                        n_bad++; $display("FAIL rnd_result got %h want %h", {ovf, zero, bout, diff}, exp_v);
                    end
                end
            end
            fire = in_valid & in_ready;
            if (fire) begin
                q.push_back(ref_model(a, b, bin));
                pushed++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL rnd_spurious got %0d want 0", spurious); end
        n_cmp++; if (pushed !== 10000 || q.size() !== 0) begin
            n_bad++; $display("FAIL rnd_complete got pushed %0d pending %0d want 10000/0", pushed, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_borrow_ripple();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
